// File: rtl/miner_pkg.sv
// Shared definitions for the nonce scheduler.
//   state_t        : search state encoding (IDLE/RUN/DRAIN/DONE)
//   OUT_W          : width of the outstanding-request counter
//   STAT_*         : bit positions inside the status byte
package miner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned OUT_W          = 4;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FOUND     = 1;
  localparam int unsigned STAT_EXHAUSTED = 2;
  localparam int unsigned STAT_ABORTED   = 3;
  localparam int unsigned STAT_OUT_LSB   = 4;

endpackage

// File: rtl/target_compare.sv
// Hit comparator: a result is a hit when it is a counted response and
// its top hash word is at or below the target (unsigned).
//   i_valid  : response strobe that is being counted
//   i_top    : most-significant 32 bits of the final hash
//   i_target : difficulty snapshot
//   o_hit    : hit indication
module target_compare (
  input  logic        i_valid,
  input  logic [31:0] i_top,
  input  logic [31:0] i_target,
  output logic        o_hit
);

  assign o_hit = i_valid && (i_top <= i_target);

endmodule

// File: rtl/nonce_scheduler.sv
// Nonce scheduler: snapshots the work item, streams nonces to the hash
// core with a bounded number of requests in flight, and records the first
// winning nonce, exhaustion of the nonce space, or an abort.
//   clk, rst                 : clock, asynchronous active-high reset
//   start, abort             : one-cycle control pulses
//   midstate/nextInput/difficulty : work item from the register block
//   core_midstate/core_input : snapshot held for the whole search
//   req_valid/req_ready/req_nonce : request handshake to the hash core
//   rsp_valid/rsp_nonce/rsp_top   : result strobe from the hash core
//   status                   : {outstanding[3:0], aborted, exhausted, found, busy}
//   nonce                    : first winning nonce of the search
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter logic [31:0] START_NONCE  = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [255:0] midstate,
  input  logic [95:0]  nextInput,
  input  logic [31:0]  difficulty,
  output logic [255:0] core_midstate,
  output logic [95:0]  core_input,
  output logic         req_valid,
  input  logic         req_ready,
  output logic [31:0]  req_nonce,
  input  logic         rsp_valid,
  input  logic [31:0]  rsp_nonce,
  input  logic [31:0]  rsp_top,
  output logic [7:0]   status,
  output logic [31:0]  nonce
);

  localparam logic [OUT_W-1:0] LP_MAX = OUT_W'(MAX_INFLIGHT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [255:0]     r_mid;
  logic [95:0]      r_input;
  logic [31:0]      r_diff;
  logic [31:0]      r_ctr;
  logic [31:0]      r_nonce;
  logic [OUT_W-1:0] r_out;
  logic [OUT_W-1:0] w_out_nxt;
  logic             r_found;
  logic             r_exh_pend;
  logic             r_exhausted;
  logic             r_aborted;

  logic             w_issue;
  logic             w_rsp;
  logic             w_hit;
  logic             w_launch;
  logic             w_abort;
  logic             w_busy;

  assign w_busy    = (r_state == RUN) || (r_state == DRAIN);
  assign req_valid = (r_state == RUN) && (r_out < LP_MAX);
  assign req_nonce = r_ctr;
  assign w_issue   = req_valid && req_ready;
  // Responses with nothing outstanding are stray (e.g. from before a reset).
  assign w_rsp     = rsp_valid && (r_out != '0);
  assign w_launch  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_abort   = abort && w_busy;

  assign core_midstate = r_mid;
  assign core_input    = r_input;
  assign nonce         = r_nonce;

  target_compare u_cmp (
    .i_valid  (w_rsp),
    .i_top    (rsp_top),
    .i_target (r_diff),
    .o_hit    (w_hit)
  );

  always_comb begin
    w_out_nxt = r_out;
    case ({w_issue, w_rsp})
      2'b10:   w_out_nxt = r_out + OUT_W'(1);
      2'b01:   w_out_nxt = r_out - OUT_W'(1);
      default: w_out_nxt = r_out;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = RUN;
      RUN: begin
        if (w_hit || w_abort || (w_issue && (r_ctr == '1)))
          w_state_nxt = DRAIN;
      end
      // Leave as soon as the count (after this cycle's response) hits zero.
      DRAIN: if (w_out_nxt == '0) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mid       <= '0;
      r_input     <= '0;
      r_diff      <= '0;
      r_ctr       <= START_NONCE;
      r_nonce     <= '0;
      r_out       <= '0;
      r_found     <= 1'b0;
      r_exh_pend  <= 1'b0;
      r_exhausted <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      if (w_launch) begin
        r_mid       <= midstate;
        r_input     <= nextInput;
        r_diff      <= difficulty;
        r_ctr       <= START_NONCE;
        r_found     <= 1'b0;
        r_exh_pend  <= 1'b0;
        r_exhausted <= 1'b0;
        r_aborted   <= 1'b0;
      end else begin
        if (w_issue) begin
          // Counter wraps after the last nonce; RUN is left so it never reissues.
          r_ctr <= r_ctr + 32'd1;
          if (r_ctr == '1) r_exh_pend <= 1'b1;
        end
        if (w_hit && !r_found) begin
          r_found <= 1'b1;
          r_nonce <= rsp_nonce;
        end
        if (w_abort) r_aborted <= 1'b1;
        // A hit arriving in the final drain cycle still suppresses exhaustion.
        if ((r_state == DRAIN) && (w_state_nxt == DONE))
          r_exhausted <= r_exh_pend && !(r_found || w_hit);
      end
    end
  end

  always_comb begin
    status = '0;
    status[STAT_BUSY]                = w_busy;
    status[STAT_FOUND]               = r_found;
    status[STAT_EXHAUSTED]           = r_exhausted;
    status[STAT_ABORTED]             = r_aborted;
    status[STAT_OUT_LSB +: OUT_W]    = r_out;
  end

endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of hash requests outstanding at once (range 1..15).
REQ-002 SHALL have parameter START_NONCE, default 32'h0, meaning the first nonce issued after start.
REQ-003 SHALL have ports, one clock and an asynchronous active-high reset, named as below:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a search.
- abort  in  1  one-cycle pulse that stops the search.
- midstate  in  256  midstate from the register block.
- nextInput  in  96  tail words from the register block.
- difficulty  in  32  target from the register block.
- core_midstate  out  256  snapshot driven to the hash core.
- core_input  out  96  snapshot driven to the hash core.
- req_valid  out  1  hash request valid.
- req_ready  in  1  hash core accepts a request.
- req_nonce  out  32  nonce of the current request.
- rsp_valid  in  1  one-cycle hash result strobe.
- rsp_nonce  in  32  nonce the result belongs to.
- rsp_top  in  32  most-significant 32 bits of the final hash.
- status  out  8  status byte read by the register block.
- nonce  out  32  winning nonce.

Function
REQ-004 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-005 SHALL, on start in IDLE or DONE, copy midstate, nextInput and difficulty into snapshot registers, load nonce counter with START_NONCE, clear found/exhausted/aborted flags, and enter RUN the next cycle.
REQ-006 SHALL ignore start in RUN or DRAIN.
REQ-007 SHALL hold core_midstate/core_input constant from the snapshot for the whole search.
REQ-008 SHALL assert req_valid in RUN only while outstanding < MAX_INFLIGHT, with req_nonce equal to the nonce counter.
REQ-009 SHALL treat a request as issued on req_valid && req_ready, then increment the nonce counter and outstanding count.
REQ-010 SHALL keep req_valid and req_nonce stable until accepted, or until the state leaves RUN.
REQ-011 SHALL decrement outstanding on each rsp_valid; simultaneous issue and response SHALL leave it unchanged.
REQ-012 SHALL declare a hit when rsp_valid && rsp_top <= difficulty snapshot (unsigned), latching rsp_nonce into nonce and setting found, only for the first hit of a search.
REQ-013 SHALL, on a hit in RUN, go to DRAIN the next cycle; a later hit SHALL not overwrite nonce.
REQ-014 SHALL, on issuing nonce 32'hFFFFFFFF, set exhausted-pending and go to DRAIN; the counter SHALL wrap without issuing again.
REQ-015 SHALL, on abort in RUN or DRAIN, set aborted and go to DRAIN; abort in IDLE/DONE SHALL be ignored.
REQ-016 SHALL, in DRAIN, issue nothing and enter DONE when outstanding == 0, including any response arriving that cycle.
REQ-017 SHALL set exhausted in DONE only if exhausted-pending is set and found is clear.
REQ-018 SHALL encode status as bit0 busy (RUN or DRAIN), bit1 found, bit2 exhausted, bit3 aborted, bits7:4 outstanding count.
REQ-019 SHALL, when hit and abort coincide, record both found and aborted.
REQ-020 SHALL ignore rsp_valid while outstanding == 0, with no underflow.

Reset
REQ-021 SHALL, on rst, asynchronously force IDLE, outstanding 0, nonce counter START_NONCE, snapshots 0, req_valid 0, nonce 0, status 8'h00 and all flags clear.
REQ-022 SHALL, on rst mid-search, discard in-flight requests; responses arriving after reset release SHALL be ignored per REQ-020.

Structure
REQ-023 SHALL place the state enumeration, status bit positions and outstanding-count width in a shared package miner_pkg.
REQ-024 SHALL be a single module; the hit comparator MAY be the sub-module target_compare.

Verification
REQ-025 SHALL cover: difficulty 32'h0000FFFF, core answering rsp_top 32'hFFFFFFFF except 32'h00001234 for nonce 7 -> nonce=7, status=8'h02.
REQ-026 SHALL cover: req_ready held low 10 cycles -> req_valid high and req_nonce stable throughout; MAX_INFLIGHT=4 with no responses -> exactly 4 issued, req_valid low.
REQ-027 SHALL cover: START_NONCE=32'hFFFFFFFD, no hits -> 3 requests issued, DONE with status=8'h04.
REQ-028 SHALL cover: abort with 3 outstanding -> no further issue; DONE after 3rd response, status=8'h08.
REQ-029 SHALL cover: issue and response in the same cycle -> outstanding unchanged; two hits for nonces 2 and 3 -> nonce=2.
REQ-030 SHALL cover: rst asserted in RUN -> status=8'h00 and req_valid=0 immediately; start after release -> req_nonce=START_NONCE.
